// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: opcodes, FSM states and op classification shared by the execute stage
package exec_stage_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8
  } op_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int COUT_IDX = 7;
  function automatic logic is_shift(input logic [3:0] op);
    return op == OP_SLL || op == OP_SRL;
  endfunction
  function automatic logic has_cout(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL};
  endfunction
  function automatic logic writes(input logic [3:0] op);
    return op == OP_MOV || has_cout(op);
  endfunction
endpackage

// File: rtl/exec_stage_alu_comb.sv
// alu_comb: combinational MOV/ADD/SUB/logic result with carry or unsigned borrow
module alu_comb
  import exec_stage_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          carry
);
  logic [DW:0] sum;
  logic [DW:0] dif;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    res = op == OP_ADD ? sum[DW-1:0] :
          op == OP_SUB ? dif[DW-1:0] :
          op == OP_AND ? a & b :
          op == OP_OR  ? a | b :
          op == OP_XOR ? a ^ b :
          op == OP_MOV ? b : '0;
    carry = op == OP_ADD ? sum[DW] : op == OP_SUB ? dif[DW] : 1'b0;
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage with iterative 1-bit-per-cycle shifter and registered
// one-cycle writeback pulses for the destination and COUT registers
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int DW    = 8,
  parameter int count = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [count-1:0] rs_idx,
  input  logic [DW-1:0]    rs_val,
  input  logic [DW-1:0]    rt_val,
  output logic             write_enable,
  output logic [count-1:0] wb_idx,
  output logic [DW-1:0]    write_data,
  output logic             cout_write_enable,
  output logic [DW-1:0]    cout_data
);
  state_t state, state_n;
  logic [DW-1:0] hold, sh, alu_res;
  logic [count-1:0] idx;
  logic [2:0] cnt, amt;
  logic dir, sh_out, alu_carry, acc, shift_now;
  alu_comb #(.DW(DW)) u_alu (
    .op(op),
    .a(rs_val),
    .b(rt_val),
    .res(alu_res),
    .carry(alu_carry)
  );
  always_comb begin
    amt = rt_val[2:0];
    in_ready = state == IDLE;
    acc = in_ready && in_valid;
    shift_now = is_shift(op) && amt != 3'd0;
    sh = dir ? hold >> 1 : hold << 1;
    sh_out = dir ? hold[0] : hold[DW-1];
    state_n = state == IDLE  ? (acc ? (shift_now ? SHIFT : DONE) : IDLE) :
              state == SHIFT ? (cnt == 3'd1 ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      idx <= '0;
      cnt <= '0;
      dir <= 1'b0;
      write_enable <= 1'b0;
      cout_write_enable <= 1'b0;
      wb_idx <= '0;
      write_data <= '0;
      cout_data <= '0;
    end else begin
      state <= state_n;
      write_enable <= 1'b0;
      cout_write_enable <= 1'b0;
      wb_idx <= '0;
      write_data <= '0;
      cout_data <= '0;
      if (acc) begin
        hold <= rs_val;
        idx <= rs_idx;
        cnt <= amt;
        dir <= op == OP_SRL;
        // shift-by-zero and all non-shift ops write back straight from the accept edge
        if (!shift_now && writes(op)) begin
          write_enable <= 1'b1;
          cout_write_enable <= has_cout(op);
          wb_idx <= rs_idx;
          write_data <= is_shift(op) ? rs_val : alu_res;
          cout_data <= {{(DW-1){1'b0}}, alu_carry};
        end
      end else if (state == SHIFT) begin
        hold <= sh;
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          write_enable <= 1'b1;
          cout_write_enable <= 1'b1;
          wb_idx <= idx;
          write_data <= sh;
          cout_data <= {{(DW-1){1'b0}}, sh_out};
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: table-driven directed checks of exec_stage plus reset-abort sequence
module tb_exec_stage;
  import exec_stage_pkg::*;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, write_enable, cout_write_enable;
  logic [3:0] op;
  logic [2:0] rs_idx, wb_idx;
  logic [7:0] rs_val, rt_val, write_data, cout_data;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [3:0] op;
    logic [2:0] idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       hold;
    int         k;
    logic       we;
    logic [2:0] wi;
    logic [7:0] wd;
    logic       cwe;
    logic [7:0] cd;
  } vec_t;
  vec_t vt[16];
  exec_stage #(.DW(8), .count(3)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .rs_idx(rs_idx),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .write_enable(write_enable),
    .wb_idx(wb_idx),
    .write_data(write_data),
    .cout_write_enable(cout_write_enable),
    .cout_data(cout_data)
  );
  always #5 clk = ~clk;
  function automatic logic [21:0] outs();
    return {in_ready, write_enable, wb_idx, write_data, cout_write_enable, cout_data};
  endfunction
  task automatic chk(input string nm, input logic [21:0] exp);
    logic [21:0] got;
    got = outs();
    total++;
    if (got !== exp)
      $display("FAIL %s: got rdy/we/idx/wd/cwe/cd=%b/%b/%h/%h/%b/%h expected %b/%b/%h/%h/%b/%h",
               nm, got[21], got[20], got[19:17], got[16:9], got[8], got[7:0],
               exp[21], exp[20], exp[19:17], exp[16:9], exp[8], exp[7:0]);
    else passed++;
  endtask
  task automatic run(input vec_t v, input int n);
    in_valid = 1'b1;
    op = v.op;
    rs_idx = v.idx;
    rs_val = v.a;
    rt_val = v.b;
    @(posedge clk);
    #1;
    in_valid = v.hold;
    rs_idx = ~v.idx;
    rs_val = ~v.a;
    rt_val = v.b ^ 8'hFE;
    for (int c = 0; c <= v.k; c++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_cyc%0d", n, c),
          c == v.k ? {1'b0, v.we, v.wi, v.wd, v.cwe, v.cd} : 22'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("vec%0d_idle", n), {1'b1, 21'd0});
  endtask
  initial begin
    vt[0]  = '{OP_ADD, 3'd2, 8'hF0, 8'h20, 1'b0, 0, 1'b1, 3'd2, 8'h10, 1'b1, 8'h01};
    vt[1]  = '{OP_SUB, 3'd3, 8'h05, 8'h07, 1'b0, 0, 1'b1, 3'd3, 8'hFE, 1'b1, 8'h01};
    vt[2]  = '{OP_SUB, 3'd4, 8'h07, 8'h05, 1'b0, 0, 1'b1, 3'd4, 8'h02, 1'b1, 8'h00};
    vt[3]  = '{OP_AND, 3'd1, 8'hCC, 8'hAA, 1'b0, 0, 1'b1, 3'd1, 8'h88, 1'b1, 8'h00};
    vt[4]  = '{OP_OR,  3'd5, 8'hCC, 8'hAA, 1'b0, 0, 1'b1, 3'd5, 8'hEE, 1'b1, 8'h00};
    vt[5]  = '{OP_XOR, 3'd6, 8'hCC, 8'hAA, 1'b0, 0, 1'b1, 3'd6, 8'h66, 1'b1, 8'h00};
    vt[6]  = '{OP_MOV, 3'd1, 8'h00, 8'h5A, 1'b1, 0, 1'b1, 3'd1, 8'h5A, 1'b0, 8'h00};
    vt[7]  = '{OP_NOP, 3'd3, 8'h11, 8'h22, 1'b0, 0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vt[8]  = '{OP_SLL, 3'd2, 8'h81, 8'h03, 1'b0, 3, 1'b1, 3'd2, 8'h08, 1'b1, 8'h00};
    vt[9]  = '{OP_SRL, 3'd5, 8'h81, 8'h01, 1'b0, 1, 1'b1, 3'd5, 8'h40, 1'b1, 8'h01};
    vt[10] = '{OP_SLL, 3'd1, 8'hA5, 8'h00, 1'b0, 0, 1'b1, 3'd1, 8'hA5, 1'b1, 8'h00};
    vt[11] = '{OP_SRL, 3'd0, 8'h80, 8'h07, 1'b0, 7, 1'b1, 3'd0, 8'h01, 1'b1, 8'h00};
    vt[12] = '{4'hF,   3'd4, 8'hFF, 8'h01, 1'b0, 0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vt[13] = '{OP_ADD, 3'd7, 8'hFF, 8'h01, 1'b0, 0, 1'b1, 3'd7, 8'h00, 1'b1, 8'h01};
    vt[14] = '{OP_SLL, 3'd6, 8'hC0, 8'h09, 1'b0, 1, 1'b1, 3'd6, 8'h80, 1'b1, 8'h01};
    vt[15] = '{OP_SRL, 3'd2, 8'h03, 8'h02, 1'b0, 2, 1'b1, 3'd2, 8'h00, 1'b1, 8'h01};
    reset = 1'b1;
    in_valid = 1'b0;
    op = 4'd0;
    rs_idx = 3'd0;
    rs_val = 8'd0;
    rt_val = 8'd0;
    #2;
    chk("reset_state", {1'b1, 21'd0});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) run(vt[i], i);
    // abort an SLL by 5 in its second SHIFT cycle with an async reset
    in_valid = 1'b1;
    op = OP_SLL;
    rs_idx = 3'd3;
    rs_val = 8'hFF;
    rt_val = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("shift_busy", 22'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_abort_now", {1'b1, 21'd0});
    @(negedge clk);
    chk("rst_held", {1'b1, 21'd0});
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    op = OP_ADD;
    rs_idx = 3'd1;
    rs_val = 8'h12;
    rt_val = 8'h34;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs_val = 8'h00;
    @(negedge clk);
    chk("post_rst_add", {1'b0, 1'b1, 3'd1, 8'h46, 1'b1, 8'h00});
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", c), {1'b1, 21'd0});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
